// File: rtl/ps2_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : ps2_pkg                                                      |
// | Description : Shared types and constants for the PS/2 host transmitter.    |
// |               Holds the transmitter state encoding, error codes, common    |
// |               command bytes and a microsecond-to-cycle helper.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package ps2_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INHIBIT   = 4'd1,
    S_RTS       = 4'd2,
    S_BITS      = 4'd3,
    S_STOP      = 4'd4,
    S_ACK       = 4'd5,
    S_WAIT_IDLE = 4'd6,
    S_DONE      = 4'd7,
    S_ERR       = 4'd8
  } ps2_tx_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NOACK   = 2'b10;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;

  // Whole cycles per microsecond times the duration; CLK_HZ is assumed to be
  // an integer number of MHz.
  function automatic int unsigned us_to_cyc(input int unsigned clk_hz,
                                            input int unsigned us);
    return (clk_hz / 32'd1_000_000) * us;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : ps2_line_sync                                                |
// | Description : Conditions one raw PS/2 pad input: 2-FF synchronizer, a      |
// |               stability filter and a falling-edge pulse.                   |
// | Ports       : clk, rst     - system clock, synchronous active-high reset   |
// |               i_pad        - raw asynchronous pad level                    |
// |               o_level      - filtered line level (resets to idle high)     |
// |               o_fall       - one-cycle pulse on a filtered 1->0 transition |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ps2_line_sync #(
  parameter int unsigned FILTER_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pad,
  output logic o_level,
  output logic o_fall
);

  localparam int unsigned          C_CNT_W    = $clog2(FILTER_CYC) + 1;
  localparam logic [C_CNT_W-1:0]   C_CNT_LAST = C_CNT_W'(FILTER_CYC - 1);
  localparam logic [C_CNT_W-1:0]   C_CNT_ONE  = C_CNT_W'(1);

  logic               r_meta;
  logic               r_sync;
  logic               r_level;
  logic               r_prev;
  logic [C_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_level <= 1'b1;
      r_prev  <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_meta <= i_pad;
      r_sync <= r_meta;
      r_prev <= r_level;
      // A new level is taken only after FILTER_CYC consecutive samples that
      // disagree with the current one; any agreeing sample restarts the count.
      if (r_sync != r_level) begin
        if (r_cnt == C_CNT_LAST) begin
          r_level <= r_sync;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + C_CNT_ONE;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_fall  = r_prev & ~r_level;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : ps2_host_tx                                                  |
// | Description : Host-to-device PS/2 command transmitter. Inhibits the bus,   |
// |               requests to send, shifts d0..d7 and odd parity on device     |
// |               clock falling edges, releases for the stop bit and checks    |
// |               the device acknowledge. Drives the open-drain pair through   |
// |               pull-low enables shared with the receive path.               |
// | Ports       : clk, rst            - clock, synchronous active-high reset   |
// |               tx_data/tx_valid    - command byte and send request          |
// |               tx_ready            - byte can be accepted                   |
// |               ps2_clk_i/data_i    - raw pad inputs                         |
// |               ps2_clk_oe/data_oe  - 1 pulls the line low                   |
// |               busy, done, err     - status and one-cycle result pulses     |
// |               err_code            - 01 timeout, 10 no acknowledge          |
// | Options     : PS2_TX_TIMEOUT_EN   - builds the device clock watchdog       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned INHIBIT_US = 100,
  parameter int unsigned RTS_US     = 1,
  parameter int unsigned TIMEOUT_US = 15000,
  parameter int unsigned FILTER_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam logic [31:0] C_INHIBIT_LD = 32'(us_to_cyc(CLK_HZ, INHIBIT_US) - 1);
  localparam logic [31:0] C_RTS_LD     = 32'(us_to_cyc(CLK_HZ, RTS_US) - 1);

  ps2_tx_state_e r_state, w_state_nxt;
  logic [31:0]   r_timer, w_timer_nxt;
  logic [8:0]    r_shift, w_shift_nxt;
  logic [3:0]    r_bitcnt, w_bitcnt_nxt;
  logic          r_data_oe, w_data_oe_nxt;
  logic [1:0]    r_err_code, w_err_code_nxt;
  logic          r_rdy_en;

  logic w_clk_level, w_clk_fall;
  logic w_data_level, w_data_fall_unused;
  logic w_accept;
  logic w_wdog_expired;

  ps2_line_sync #(.FILTER_CYC(FILTER_CYC)) u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pad   (ps2_clk_i),
    .o_level (w_clk_level),
    .o_fall  (w_clk_fall)
  );

  ps2_line_sync #(.FILTER_CYC(FILTER_CYC)) u_data_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pad   (ps2_data_i),
    .o_level (w_data_level),
    .o_fall  (w_data_fall_unused)
  );

  assign w_accept = tx_valid && tx_ready;

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [31:0] C_WDOG_LD = 32'(us_to_cyc(CLK_HZ, TIMEOUT_US) - 1);

  logic [31:0] r_wdog;
  logic        w_wdog_active;

  assign w_wdog_active  = (r_state == S_BITS) || (r_state == S_STOP) || (r_state == S_ACK);
  assign w_wdog_expired = w_wdog_active && !w_clk_fall && (r_wdog == 32'd0);

  // Reloaded when the device is first given the clock and on every edge, so
  // it measures the gap between consecutive device falling edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdog <= '0;
    end else if (((r_state == S_RTS) && (w_state_nxt == S_BITS)) ||
                 (w_wdog_active && w_clk_fall)) begin
      r_wdog <= C_WDOG_LD;
    end else if (r_wdog != 32'd0) begin
      r_wdog <= r_wdog - 32'd1;
    end
  end
`else
  // No watchdog: only rst can leave a stalled transfer. The wire below keeps
  // TIMEOUT_US referenced in this build.
  logic [31:0] w_timeout_cyc_unused;
  assign w_timeout_cyc_unused = 32'(us_to_cyc(CLK_HZ, TIMEOUT_US));
  assign w_wdog_expired       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_shift    <= '0;
      r_bitcnt   <= '0;
      r_data_oe  <= 1'b0;
      r_err_code <= ERR_NONE;
      r_rdy_en   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_timer    <= w_timer_nxt;
      r_shift    <= w_shift_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_err_code <= w_err_code_nxt;
      r_rdy_en   <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_shift_nxt    = r_shift;
    w_bitcnt_nxt   = r_bitcnt;
    w_data_oe_nxt  = r_data_oe;
    w_err_code_nxt = r_err_code;

    case (r_state)
      S_IDLE: begin
        w_data_oe_nxt = 1'b0;
        if (w_accept) begin
          w_state_nxt    = S_INHIBIT;
          w_timer_nxt    = C_INHIBIT_LD;
          w_shift_nxt    = {~^tx_data, tx_data};
          w_bitcnt_nxt   = 4'd0;
          w_err_code_nxt = ERR_NONE;
        end
      end
      S_INHIBIT: begin
        if (r_timer == 32'd0) begin
          w_state_nxt   = S_RTS;
          w_timer_nxt   = C_RTS_LD;
          w_data_oe_nxt = 1'b1;              // start bit
        end else begin
          w_timer_nxt = r_timer - 32'd1;
        end
      end
      S_RTS: begin
        if (r_timer == 32'd0) begin
          w_state_nxt = S_BITS;
        end else begin
          w_timer_nxt = r_timer - 32'd1;
        end
      end
      S_BITS: begin
        // Edges 1..9 present d0..d7 then parity, LSB first out of r_shift.
        if (w_clk_fall) begin
          w_data_oe_nxt = ~r_shift[0];
          w_shift_nxt   = {1'b0, r_shift[8:1]};
          w_bitcnt_nxt  = r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd8) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (w_clk_fall) begin
          w_data_oe_nxt = 1'b0;
          w_bitcnt_nxt  = r_bitcnt + 4'd1;
          w_state_nxt   = S_ACK;
        end
      end
      S_ACK: begin
        if (w_clk_fall) begin
          if (!w_data_level) begin
            w_state_nxt = S_WAIT_IDLE;
          end else begin
            w_state_nxt    = S_ERR;
            w_err_code_nxt = ERR_NOACK;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (w_clk_level && w_data_level) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        w_data_oe_nxt = 1'b0;
        w_state_nxt   = S_IDLE;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_data_oe_nxt = 1'b0;
      end
    endcase

    if (w_wdog_expired) begin
      w_state_nxt    = S_ERR;
      w_err_code_nxt = ERR_TIMEOUT;
      w_data_oe_nxt  = 1'b0;
    end
  end

  assign tx_ready    = r_rdy_en && (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign err         = (r_state == S_ERR);
  assign ps2_clk_oe  = (r_state == S_INHIBIT) || (r_state == S_RTS);
  assign ps2_data_oe = r_data_oe;
  assign err_code    = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_ps2_host_tx                                               |
// | Description : Scoreboard bench for ps2_host_tx with an open-drain PS/2     |
// |               device model. Expected outcomes are queued at send time and  |
// |               popped by a monitor on every done/err pulse.                 |
// | Options     : PS2_TX_TIMEOUT_EN   - adds the watchdog scenario             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int HALF        = 40;    // device clock half period, in clk cycles
  localparam int INHIBIT_CYC = 1000;  // 10 us at 100 MHz
  localparam int RTS_CYC     = 100;   // 1 us at 100 MHz
`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT_US = 3;   // 300 cycles
`else
  localparam int unsigned TB_TIMEOUT_US = 15000;
`endif

  typedef struct {
    logic [1:0]  kind;       // {done, err}
    logic [1:0]  code;
    logic [10:0] frame;      // bit 0 = start bit ... bit 10 = stop bit
    bit          has_frame;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, done, err;
  logic [1:0] err_code;
  logic       dev_clk_low, dev_data_low;
  logic       clk_line, data_line;

  exp_t        exp_q[$];
  logic [10:0] cap_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;

  assign clk_line  = ~(ps2_clk_oe  | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .CLK_HZ     (100_000_000),
    .INHIBIT_US (10),
    .RTS_US     (1),
    .TIMEOUT_US (TB_TIMEOUT_US),
    .FILTER_CYC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .ps2_clk_i   (clk_line),
    .ps2_data_i  (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_code    (err_code)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] kind, input logic [1:0] code,
                              input logic [10:0] frame, input bit has_frame);
    exp_t e;
    e.kind = kind; e.code = code; e.frame = frame; e.has_frame = has_frame;
    return e;
  endfunction

  // Monitor: every result pulse consumes one queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1 || err === 1'b1) begin
      if (done === 1'b1 && err === 1'b1) chk("done_err_together", 1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", {done, err}, 2'b00);
      end else begin
        mon_e = exp_q.pop_front();
        chk("outcome", {done, err}, mon_e.kind);
        chk("err_code", err_code, mon_e.code);
        if (mon_e.has_frame) begin
          if (cap_q.size() == 0) chk("frame_missing", 0, 1);
          else                   chk("frame", cap_q.pop_front(), mon_e.frame);
        end
      end
    end
  end

  // Device model: waits for the host to release the clock, then clocks
  // n_edges falling edges, sampling the data line late in each low phase.
  task automatic dev_frame(input bit ack, input int n_edges, output int oe_cyc);
    logic [10:0] fr;
    fr = '0;
    oe_cyc = 0;
    while (ps2_clk_oe === 1'b1 && oe_cyc < 20000) begin
      oe_cyc++;
      @(negedge clk);
    end
    repeat (HALF) @(negedge clk);
    fr[0] = data_line;
    for (int k = 1; k <= n_edges && k <= 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      fr[k] = data_line;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    if (n_edges == 11) begin
      cap_q.push_back(fr);
      if (ack) dev_data_low = 1'b1;
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic hold_watch();
    int hi;
    int t;
    hi = 0;
    t  = 0;
    while (!(done === 1'b1 || err === 1'b1) && t < 5000) begin
      if (tx_ready === 1'b1) hi++;
      @(negedge clk);
      t++;
    end
    tx_valid = 1'b0;
    chk("hold_ready_low_while_busy", hi, 0);
    chk("hold_done_seen", (t < 5000), 1);
    @(negedge clk);
    chk("hold_ready_after_done", tx_ready, 1);
  endtask

  task automatic do_xfer(input logic [7:0] b, input bit ack, input int n_edges,
                         input bit hold, input bit push, input exp_t e);
    int t;
    int oe_cyc;
    t = 0;
    while (tx_ready !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_send", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    chk("accept_clk_oe", ps2_clk_oe, 1);
    chk("accept_busy", busy, 1);
    chk("accept_ready_low", tx_ready, 0);
    if (!hold) tx_valid = 1'b0;
    fork
      dev_frame(ack, n_edges, oe_cyc);
      if (hold) hold_watch();
    join
    chk("inhibit_rts_len", oe_cyc, INHIBIT_CYC + RTS_CYC);
    if (n_edges == 11) begin
      t = 0;
      while (tx_ready !== 1'b1 && t < 5000) begin
        @(negedge clk);
        t++;
      end
      chk("ready_after_xfer", tx_ready, 1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t v_exp [4];
    logic [7:0] v_byte [4];
    bit         v_ack  [4];
    int         t;

    rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);

    rst = 1'b0;
    #1 chk("ready_low_as_rst_falls", tx_ready, 0);
    @(negedge clk);
    chk("ready_one_cycle_after_rst", tx_ready, 1);

    // Frames as {stop, parity, d7..d0, start}.
    v_byte[0] = PS2_CMD_ENABLE; v_ack[0] = 1'b1;
    v_exp[0]  = mk(2'b10, 2'b00, 11'b1_0_11110100_0, 1'b1);
    v_byte[1] = 8'h00;          v_ack[1] = 1'b1;
    v_exp[1]  = mk(2'b10, 2'b00, 11'b1_1_00000000_0, 1'b1);
    v_byte[2] = 8'hFF;          v_ack[2] = 1'b1;
    v_exp[2]  = mk(2'b10, 2'b00, 11'b1_1_11111111_0, 1'b1);
    v_byte[3] = PS2_CMD_ENABLE; v_ack[3] = 1'b0;
    v_exp[3]  = mk(2'b01, 2'b10, 11'b1_0_11110100_0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      do_xfer(v_byte[i], v_ack[i], 11, 1'b0, 1'b1, v_exp[i]);
    end

    // Reset in the middle of the data bits: after 4 edges d3 of 0xF4 (0)
    // is on the line, so data_oe is 1.
    do_xfer(8'hF4, 1'b1, 4, 1'b0, 1'b0, mk(2'b00, 2'b00, 11'd0, 1'b0));
    chk("mid_busy", busy, 1);
    chk("mid_data_oe_d3", ps2_data_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("rst_mid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_mid_ready_low", tx_ready, 0);
    @(negedge clk);
    chk("rst_mid_ready_high", tx_ready, 1);
    repeat (5) @(negedge clk);

    do_xfer(8'hF4, 1'b1, 11, 1'b0, 1'b1, mk(2'b10, 2'b00, 11'b1_0_11110100_0, 1'b1));

    // tx_valid held high for the whole transfer.
    do_xfer(8'hF4, 1'b1, 11, 1'b1, 1'b1, mk(2'b10, 2'b00, 11'b1_0_11110100_0, 1'b1));
    repeat (5) @(negedge clk);
    chk("hold_single_xfer", busy, 0);

`ifdef PS2_TX_TIMEOUT_EN
    // Device stops after 4 edges; the watchdog must end the transfer.
    do_xfer(8'hF4, 1'b1, 4, 1'b0, 1'b1, mk(2'b01, 2'b01, 11'd0, 1'b0));
    t = 0;
    while (err !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("timeout_err_seen", err, 1);
    chk("timeout_latency_window", (t > 100) && (t < 400), 1);
    @(negedge clk);
    chk("timeout_oe_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("timeout_code_held", err_code, 2'b01);
`else
    t = 0;
`endif

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("frames_drained", cap_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
